// File: rtl/mar_access_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mar_access_arbiter_if
//  Description : Bundle between the MAR requesters and the MAR access
//                arbiter.
//                Requester side (driven by requesters):
//                  req      - per-requester request level
//                  req_addr - packed address nibbles, slot i at [i*ADDR_W +: ADDR_W]
//                  req_sel  - packed select codes, slot i at [i*SEL_W +: SEL_W]
//                Arbiter side (driven by the arbiter):
//                  gnt      - registered one-hot grant
//                  done     - one-cycle completion pulse to the granted requester
//                  mar_d    - MAR data bus
//                  mar_sel  - MAR select
//                  mar_g    - MAR load strobe, active high
//                  mar_g1_n - MAR enable 1, active low
//                  mar_g2_n - MAR enable 2, active low
//                  busy     - arbiter is in a transaction
//                  gnt_id   - index of the current or last grant
//                Modports: master = requester side, slave = arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mar_access_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int SEL_W   = 2
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*SEL_W-1:0]  req_sel;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [ADDR_W-1:0]         mar_d;
  logic [SEL_W-1:0]          mar_sel;
  logic                      mar_g;
  logic                      mar_g1_n;
  logic                      mar_g2_n;
  logic                      busy;
  logic [ID_W-1:0]           gnt_id;

  modport master (
    output req, req_addr, req_sel,
    input  gnt, done, mar_d, mar_sel, mar_g, mar_g1_n, mar_g2_n, busy, gnt_id
  );

  modport slave (
    input  req, req_addr, req_sel,
    output gnt, done, mar_d, mar_sel, mar_g, mar_g1_n, mar_g2_n, busy, gnt_id
  );
endinterface
`default_nettype wire

// File: rtl/mar_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mar_access_arbiter
//  Description : Round-robin arbiter and load sequencer for the shared memory
//                address register (MAR). One requester is granted at a time;
//                its address/select are captured at the grant edge and driven
//                onto the MAR through a setup / strobe / hold sequence.
//  Ports       : clk - system clock, rising edge
//                rst - synchronous active-high reset
//                bus - mar_access_arbiter_if.slave (requests in, grant, done,
//                      MAR bus, busy and gnt_id out)
//  Parameters  : NUM_REQ (2..8), ADDR_W, SEL_W, SETUP_CYC (1..7),
//                HOLD_CYC (1..7). NUM_REQ/ADDR_W/SEL_W must match the
//                interface instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module mar_access_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 4,
  parameter int SEL_W     = 2,
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mar_access_arbiter_if.slave   bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_nx;
  logic [ID_W-1:0]     gnt_id_q, gnt_id_nx;
  logic [NUM_REQ-1:0]  gnt_q, gnt_nx;
  logic [NUM_REQ-1:0]  done_q, done_nx;
  logic [ADDR_W-1:0]   mar_d_q, mar_d_nx;
  logic [SEL_W-1:0]    mar_sel_q, mar_sel_nx;
  logic                mar_g_q, mar_g_nx;
  logic                en_n_q, en_n_nx;
  logic                busy_q, busy_nx;

  // Round-robin pick: first set request bit at or above rr_ptr, wrapping.
  logic                win_found;
  logic [ID_W-1:0]     win_id;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!win_found && bus.req[(int'(rr_ptr) + off) % NUM_REQ]) begin
        win_found = 1'b1;
        win_id    = ID_W'((int'(rr_ptr) + off) % NUM_REQ);
      end
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      gnt_id_q  <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      mar_d_q   <= '0;
      mar_sel_q <= '0;
      mar_g_q   <= 1'b0;
      en_n_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rr_ptr    <= rr_ptr_nx;
      gnt_id_q  <= gnt_id_nx;
      gnt_q     <= gnt_nx;
      done_q    <= done_nx;
      mar_d_q   <= mar_d_nx;
      mar_sel_q <= mar_sel_nx;
      mar_g_q   <= mar_g_nx;
      en_n_q    <= en_n_nx;
      busy_q    <= busy_nx;
    end
  end

  // Next-state and next-output logic. Outputs are computed for the state
  // being entered so that every MAR line comes straight from a flop.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    rr_ptr_nx  = rr_ptr;
    gnt_id_nx  = gnt_id_q;
    gnt_nx     = gnt_q;
    done_nx    = '0;
    mar_d_nx   = mar_d_q;
    mar_sel_nx = mar_sel_q;
    mar_g_nx   = 1'b0;
    en_n_nx    = 1'b1;

    case (state)
      IDLE: begin
        gnt_nx = '0;
        if (win_found) begin
          // Address and select are captured once, here; later changes on the
          // requester side are ignored for the rest of the transaction.
          state_nx   = SETUP;
          cnt_nx     = '0;
          gnt_nx     = NUM_REQ'(1) << win_id;
          gnt_id_nx  = win_id;
          mar_d_nx   = bus.req_addr[int'(win_id)*ADDR_W +: ADDR_W];
          mar_sel_nx = bus.req_sel[int'(win_id)*SEL_W +: SEL_W];
          en_n_nx    = 1'b0;
        end
      end

      SETUP: begin
        // The first SETUP cycle is the one in which data and enables change
        // together; SETUP_CYC further cycles of stable data follow before
        // the strobe, so SETUP occupies SETUP_CYC+1 clocks in total.
        en_n_nx = 1'b0;
        if (cnt == CNT_W'(SETUP_CYC)) begin
          state_nx = STROBE;
          cnt_nx   = '0;
          mar_g_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      STROBE: begin
        en_n_nx  = 1'b0;
        state_nx = HOLD;
        cnt_nx   = '0;
        // With a single hold cycle the first HOLD cycle is also the last.
        if (HOLD_CYC == 1) begin
          done_nx = NUM_REQ'(1) << gnt_id_q;
        end
      end

      HOLD: begin
        if (cnt == CNT_W'(HOLD_CYC - 1)) begin
          state_nx  = IDLE;
          cnt_nx    = '0;
          gnt_nx    = '0;
          en_n_nx   = 1'b1;
          rr_ptr_nx = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
        end else begin
          en_n_nx = 1'b0;
          cnt_nx  = cnt + 1'b1;
          // done goes out with the last HOLD cycle.
          if ((cnt + 1'b1) == CNT_W'(HOLD_CYC - 1)) begin
            done_nx = NUM_REQ'(1) << gnt_id_q;
          end
        end
      end

      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.mar_d    = mar_d_q;
  assign bus.mar_sel  = mar_sel_q;
  assign bus.mar_g    = mar_g_q;
  // Both enables move together; the strobe is only ever raised while
  // en_n_q is low.
  assign bus.mar_g1_n = en_n_q;
  assign bus.mar_g2_n = en_n_q;
  assign bus.busy     = busy_q;
  assign bus.gnt_id   = gnt_id_q;

endmodule
`default_nettype wire

// File: tb/tb_mar_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mar_access_arbiter
//  Description : Directed self-checking bench for mar_access_arbiter. One
//                instance uses default timing, a second uses SETUP_CYC=3,
//                HOLD_CYC=2. Inputs are driven and outputs sampled 1 time
//                unit after each rising clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mar_access_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mar_access_arbiter_if #(.NUM_REQ(4), .ADDR_W(4), .SEL_W(2)) bus ();
  mar_access_arbiter_if #(.NUM_REQ(4), .ADDR_W(4), .SEL_W(2)) bus_p ();

  mar_access_arbiter #(
    .NUM_REQ(4), .ADDR_W(4), .SEL_W(2), .SETUP_CYC(1), .HOLD_CYC(1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  mar_access_arbiter #(
    .NUM_REQ(4), .ADDR_W(4), .SEL_W(2), .SETUP_CYC(3), .HOLD_CYC(2)
  ) dut_p (
    .clk(clk), .rst(rst), .bus(bus_p)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {gnt, done, mar_g, mar_g1_n, mar_g2_n, busy}
  function automatic logic [11:0] ctl(input logic [3:0] g, input logic [3:0] d,
                                      input logic s, input logic e1,
                                      input logic e2, input logic b);
    return {g, d, s, e1, e2, b};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if ({bus.gnt, bus.done, bus.mar_d, bus.mar_sel, bus.mar_g, bus.mar_g1_n,
         bus.mar_g2_n, bus.busy, bus.gnt_id} !== 20'b0000_0000_0000_00_0_1_1_0_00) begin
      miscompares++;
      $display("FAIL reset_state: got gnt=%b done=%b d=%b sel=%b g=%b g1n=%b g2n=%b busy=%b id=%0d, required all idle",
               bus.gnt, bus.done, bus.mar_d, bus.mar_sel, bus.mar_g, bus.mar_g1_n,
               bus.mar_g2_n, bus.busy, bus.gnt_id);
    end
    vectors++;
    if ({bus_p.gnt, bus_p.mar_g, bus_p.mar_g1_n, bus_p.busy} !== 7'b0000_0_1_0) begin
      miscompares++;
      $display("FAIL reset_state_p: got gnt=%b g=%b g1n=%b busy=%b, required 0000 0 1 0",
               bus_p.gnt, bus_p.mar_g, bus_p.mar_g1_n, bus_p.busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [11:0] tab [5];
    tab = '{ctl(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1),
            ctl(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1),
            ctl(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1),
            ctl(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1),
            ctl(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0)};
    bus.req_addr[3:0] = 4'b1010;
    bus.req_sel[1:0]  = 2'b00;
    bus.req           = 4'b0001;
    step();
    bus.req = 4'b0000;
    vectors++;
    if (bus.mar_d !== 4'b1010 || bus.gnt_id !== 2'd0) begin
      miscompares++;
      $display("FAIL single_capture: got mar_d=%b id=%0d, required 1010 id=0", bus.mar_d, bus.gnt_id);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      vectors++;
      if ({bus.gnt, bus.done, bus.mar_g, bus.mar_g1_n, bus.mar_g2_n, bus.busy} !== tab[i]) begin
        miscompares++;
        $display("FAIL single_seq c%0d: got %b, required %b", i + 1,
                 {bus.gnt, bus.done, bus.mar_g, bus.mar_g1_n, bus.mar_g2_n, bus.busy}, tab[i]);
      end
    end
    vectors++;
    if (bus.mar_d !== 4'b1010) begin
      miscompares++;
      $display("FAIL single_hold_idle: got mar_d=%b, required 1010", bus.mar_d);
    end
  endtask

  task automatic test_simultaneous();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_addr = {4'b0000, 4'b1111, 4'b0000, 4'b1010};
    bus.req_sel  = {2'b00, 2'b01, 2'b00, 2'b00};
    bus.req      = 4'b0101;
    step();
    vectors++;
    if (bus.gnt !== 4'b0001 || bus.mar_d !== 4'b1010 || bus.gnt_id !== 2'd0) begin
      miscompares++;
      $display("FAIL simul_first: got gnt=%b d=%b id=%0d, required 0001 1010 0", bus.gnt, bus.mar_d, bus.gnt_id);
    end
    step(); step(); step();
    vectors++;
    if (bus.done !== 4'b0001) begin
      miscompares++;
      $display("FAIL simul_done0: got done=%b, required 0001", bus.done);
    end
    step();
    bus.req = 4'b0100;
    vectors++;
    if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL simul_gap: got busy=%b gnt=%b, required 0 0000", bus.busy, bus.gnt);
    end
    step();
    vectors++;
    if (bus.gnt !== 4'b0100 || bus.mar_d !== 4'b1111 || bus.mar_sel !== 2'b01 || bus.gnt_id !== 2'd2) begin
      miscompares++;
      $display("FAIL simul_second: got gnt=%b d=%b sel=%b id=%0d, required 0100 1111 01 2",
               bus.gnt, bus.mar_d, bus.mar_sel, bus.gnt_id);
    end
    step(); step(); step();
    bus.req = 4'b0000;
    vectors++;
    if (bus.done !== 4'b0100) begin
      miscompares++;
      $display("FAIL simul_done2: got done=%b, required 0100", bus.done);
    end
    step();
  endtask

  task automatic test_fairness();
    bus.req_addr = {4'd8, 4'd7, 4'd6, 4'd5};
    bus.req      = 4'b1111;
    // rr_ptr is 3 after requester 2 was served; start from a clean pointer.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      int exp_id;
      exp_id = t % 4;
      step();
      vectors++;
      if (bus.gnt !== 4'(1 << exp_id) || bus.gnt_id !== 2'(exp_id) || bus.mar_d !== 4'(exp_id + 5)) begin
        miscompares++;
        $display("FAIL fair_grant t=%0d: got gnt=%b id=%0d d=%0d, required id=%0d d=%0d",
                 t, bus.gnt, bus.gnt_id, bus.mar_d, exp_id, exp_id + 5);
      end
      step(); step(); step();
      vectors++;
      if (bus.done !== 4'(1 << exp_id)) begin
        miscompares++;
        $display("FAIL fair_done t=%0d: got done=%b, required id=%0d", t, bus.done, exp_id);
      end
      step();
      vectors++;
      if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
        miscompares++;
        $display("FAIL fair_gap t=%0d: got busy=%b gnt=%b, required 0 0000", t, bus.busy, bus.gnt);
      end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_mid_drop();
    // rr_ptr is 1 here, last grant went to requester 0.
    bus.req_addr[7:4] = 4'b0110;
    bus.req_sel[3:2]  = 2'b11;
    bus.req           = 4'b0010;
    step();
    bus.req           = 4'b0000;
    bus.req_addr[7:4] = 4'b0001;
    bus.req_sel[3:2]  = 2'b00;
    vectors++;
    if (bus.gnt !== 4'b0010 || bus.gnt_id !== 2'd1) begin
      miscompares++;
      $display("FAIL drop_grant: got gnt=%b id=%0d, required 0010 1", bus.gnt, bus.gnt_id);
    end
    step(); step();
    vectors++;
    if (bus.mar_g !== 1'b1 || bus.mar_d !== 4'b0110 || bus.mar_sel !== 2'b11) begin
      miscompares++;
      $display("FAIL drop_strobe: got g=%b d=%b sel=%b, required 1 0110 11", bus.mar_g, bus.mar_d, bus.mar_sel);
    end
    step();
    vectors++;
    if (bus.done !== 4'b0010 || bus.mar_d !== 4'b0110) begin
      miscompares++;
      $display("FAIL drop_done: got done=%b d=%b, required 0010 0110", bus.done, bus.mar_d);
    end
    step();
    // A request that goes away before the arbiter samples it is never seen.
    bus.req = 4'b0100;
    #2;
    bus.req = 4'b0000;
    step();
    vectors++;
    if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL short_req: got busy=%b gnt=%b, required 0 0000", bus.busy, bus.gnt);
    end
  endtask

  task automatic test_reset_strobe();
    // rr_ptr is 2; only requester 3 asks.
    bus.req = 4'b1000;
    step();
    bus.req = 4'b0000;
    step(); step();
    vectors++;
    if (bus.mar_g !== 1'b1 || bus.gnt !== 4'b1000) begin
      miscompares++;
      $display("FAIL rst_pre: got g=%b gnt=%b, required 1 1000", bus.mar_g, bus.gnt);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if ({bus.gnt, bus.done, bus.mar_g, bus.mar_g1_n, bus.mar_g2_n, bus.busy} !== 12'b0000_0000_0110) begin
      miscompares++;
      $display("FAIL rst_strobe: got %b, required 000000000110",
               {bus.gnt, bus.done, bus.mar_g, bus.mar_g1_n, bus.mar_g2_n, bus.busy});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (bus.done !== 4'b0000 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_quiet c%0d: got done=%b busy=%b, required 0000 0", i, bus.done, bus.busy);
      end
    end
    bus.req = 4'b1111;
    step();
    bus.req = 4'b0000;
    vectors++;
    if (bus.gnt !== 4'b0001 || bus.gnt_id !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_rrptr: got gnt=%b id=%0d, required 0001 0", bus.gnt, bus.gnt_id);
    end
    step(); step(); step(); step();
  endtask

  task automatic test_param_timing();
    logic [11:0] tab [8];
    int busy_cnt;
    busy_cnt = 0;
    tab = '{ctl(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1),
            ctl(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1),
            ctl(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1),
            ctl(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1),
            ctl(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1),
            ctl(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1),
            ctl(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1),
            ctl(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0)};
    bus_p.req_addr[7:4] = 4'b1100;
    bus_p.req_sel[3:2]  = 2'b10;
    bus_p.req           = 4'b0010;
    step();
    bus_p.req = 4'b0000;
    vectors++;
    if (bus_p.mar_d !== 4'b1100 || bus_p.mar_sel !== 2'b10 || bus_p.gnt_id !== 2'd1) begin
      miscompares++;
      $display("FAIL param_capture: got d=%b sel=%b id=%0d, required 1100 10 1",
               bus_p.mar_d, bus_p.mar_sel, bus_p.gnt_id);
    end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      if (bus_p.busy === 1'b1) busy_cnt++;
      vectors++;
      if ({bus_p.gnt, bus_p.done, bus_p.mar_g, bus_p.mar_g1_n, bus_p.mar_g2_n, bus_p.busy} !== tab[i]) begin
        miscompares++;
        $display("FAIL param_seq c%0d: got %b, required %b", i + 1,
                 {bus_p.gnt, bus_p.done, bus_p.mar_g, bus_p.mar_g1_n, bus_p.mar_g2_n, bus_p.busy}, tab[i]);
      end
    end
    vectors++;
    if (busy_cnt != 7) begin
      miscompares++;
      $display("FAIL param_busy_len: got %0d cycles, required 7", busy_cnt);
    end
  endtask

  initial begin
    bus.req        = '0;
    bus.req_addr   = '0;
    bus.req_sel    = '0;
    bus_p.req      = '0;
    bus_p.req_addr = '0;
    bus_p.req_sel  = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_mid_drop();
    test_reset_strobe();
    test_param_timing();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
